trig_cordic: RTL and testbench

TRIG_CORDIC -- requirements
Module: trig_cordic

---
 rtl/trig_cordic.sv | 180 ++++++++++++++++++
 tb/tb_trig_cordic.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/trig_cordic.sv
// trig_cordic: iterative 12-step rotation-mode CORDIC producing Q1.10 sine and cosine
// of a 4.8 fixed-point angle in radians.
// Optional feature: define TRIG_SAT_EN to clamp the final results to [-1023, +1023].
module trig_cordic (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [11:0] theta,
  output logic        busy,
  output logic        done,
  output logic [11:0] sin_out,
  output logic [11:0] cos_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic signed [15:0] r_x;
  logic signed [15:0] r_y;
  logic signed [15:0] r_z;
  logic        [3:0]  r_i;
  logic               r_neg;
  logic        [11:0] r_sin;
  logic        [11:0] r_cos;

  logic signed [15:0] w_thetaQ;
  logic signed [15:0] w_zInit;
  logic               w_negInit;
  logic signed [15:0] w_atan;
  logic               w_d;
  logic signed [15:0] w_xShift;
  logic signed [15:0] w_yShift;
  logic signed [15:0] w_xNext;
  logic signed [15:0] w_yNext;
  logic signed [15:0] w_zNext;
  logic        [11:0] w_cosRaw;
  logic        [11:0] w_sinRaw;
  logic        [11:0] w_cosVal;
  logic        [11:0] w_sinVal;
  logic        [11:0] w_cosLoad;
  logic        [11:0] w_sinLoad;

`ifdef TRIG_SAT_EN
  function automatic logic [11:0] clampQ(input logic [11:0] v);
    logic signed [11:0] s;
    s = v;
    if (s > 12'sd1023)       return 12'h3FF;
    else if (s < -12'sd1023) return 12'hC01;
    else                     return v;
  endfunction
`endif

  assign w_thetaQ = {theta, 4'b0000};

  // Fold the angle into [-pi/2, pi/2); the middle half-turn is rotated by pi and the result negated.
  always_comb begin
    w_zInit   = w_thetaQ;
    w_negInit = 1'b0;
    if (theta < 12'h192) begin
      w_zInit   = w_thetaQ;
      w_negInit = 1'b0;
    end else if (theta < 12'h4B6) begin
      w_zInit   = w_thetaQ - 16'sh3244;
      w_negInit = 1'b1;
    end else begin
      w_zInit   = w_thetaQ - 16'sh6488;
      w_negInit = 1'b0;
    end
  end

  // Arctangent of 2^-i in Q4.12 for the current iteration.
  always_comb begin
    w_atan = 16'sh0000;
    case (r_i)
      4'd0:  w_atan = 16'sh0C91;
      4'd1:  w_atan = 16'sh076B;
      4'd2:  w_atan = 16'sh03EB;
      4'd3:  w_atan = 16'sh01FD;
      4'd4:  w_atan = 16'sh0100;
      4'd5:  w_atan = 16'sh0080;
      4'd6:  w_atan = 16'sh0040;
      4'd7:  w_atan = 16'sh0020;
      4'd8:  w_atan = 16'sh0010;
      4'd9:  w_atan = 16'sh0008;
      4'd10: w_atan = 16'sh0004;
      4'd11: w_atan = 16'sh0002;
      default: w_atan = 16'sh0000;
    endcase
  end

  // One micro-rotation: direction follows the sign of the residual angle, all terms from current registers.
  always_comb begin
    w_d      = ~r_z[15];
    w_xShift = r_x >>> r_i;
    w_yShift = r_y >>> r_i;
    w_xNext  = w_d ? (r_x - w_yShift) : (r_x + w_yShift);
    w_yNext  = w_d ? (r_y + w_xShift) : (r_y - w_xShift);
    w_zNext  = w_d ? (r_z - w_atan)   : (r_z + w_atan);
  end

  // Final results: Q2.14 truncated to Q1.10, negated for the middle half-turn, optionally clamped.
  always_comb begin
    w_cosRaw = w_xNext[15:4];
    w_sinRaw = w_yNext[15:4];
    w_cosVal = r_neg ? (12'd0 - w_cosRaw) : w_cosRaw;
    w_sinVal = r_neg ? (12'd0 - w_sinRaw) : w_sinRaw;
`ifdef TRIG_SAT_EN
    w_cosLoad = clampQ(w_cosVal);
    w_sinLoad = clampQ(w_sinVal);
`else
    w_cosLoad = w_cosVal;
    w_sinLoad = w_sinVal;
`endif
  end

  // State register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  // Next-state: start only honoured in IDLE, twelve iterations, single DONE cycle.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (start) w_stateNext = ITER;
      ITER:    if (r_i == 4'd11) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Datapath: load on accept, rotate during ITER, capture results on the last iteration.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_x   <= 16'sh0000;
      r_y   <= 16'sh0000;
      r_z   <= 16'sh0000;
      r_i   <= 4'd0;
      r_neg <= 1'b0;
      r_sin <= 12'h000;
      r_cos <= 12'h000;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x   <= 16'sh26DD;
            r_y   <= 16'sh0000;
            r_z   <= w_zInit;
            r_i   <= 4'd0;
            r_neg <= w_negInit;
          end
        end
        ITER: begin
          r_x <= w_xNext;
          r_y <= w_yNext;
          r_z <= w_zNext;
          r_i <= r_i + 4'd1;
          if (r_i == 4'd11) begin
            r_cos <= w_cosLoad;
            r_sin <= w_sinLoad;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign sin_out = r_sin;
  assign cos_out = r_cos;

endmodule

// File: tb/tb_trig_cordic.sv
// tb_trig_cordic: self-checking bench for trig_cordic; results are compared against
// ideal sine/cosine of the sampled angle within the +/-3 LSB accuracy window.
module tb_trig_cordic;

  logic        Clk   = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] theta = 12'h000;
  logic        busy;
  logic        done;
  logic [11:0] sin_out;
  logic [11:0] cos_out;

  int checks = 0;
  int errors = 0;

  trig_cordic dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .start   (start),
    .theta   (theta),
    .busy    (busy),
    .done    (done),
    .sin_out (sin_out),
    .cos_out (cos_out)
  );

  always #5 Clk = ~Clk;

  // Ideal Q1.10 sine/cosine of a 4.8 radian angle, clamped when saturation is built in.
  task automatic refTrig(input logic [11:0] th, output int s, output int c);
    real a;
    a = real'(th) / 256.0;
    s = int'($sin(a) * 1024.0);
    c = int'($cos(a) * 1024.0);
`ifdef TRIG_SAT_EN
    if (s > 1023)  s = 1023;
    if (s < -1023) s = -1023;
    if (c > 1023)  c = 1023;
    if (c < -1023) c = -1023;
`endif
  endtask

  // Issue one start pulse and wait (bounded) for done; lat is edges after the accepting edge, -1 on timeout.
  task automatic applyStimulus(input logic [11:0] th, output int lat, output int s, output int c);
    lat = -1;
    s   = 99999;
    c   = 99999;
    start = 1'b1;
    theta = th;
    @(posedge Clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge Clk); #1;
      if (done === 1'b1) begin
        lat = k;
        s   = $signed(sin_out);
        c   = $signed(cos_out);
        break;
      end
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    start = 1'b1;
    theta = 12'h100;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (sin_out !== 12'h000) begin errors++; $display("[TB] FAIL reset_sin got %h want 000", sin_out); end
    checks++; if (cos_out !== 12'h000) begin errors++; $display("[TB] FAIL reset_cos got %h want 000", cos_out); end
    Reset = 1'b0;
    start = 1'b0;
    @(posedge Clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset got %b want 0", busy); end
  endtask

  task automatic test_corners;
    logic [11:0] angles [4];
    int lat, s, c, es, ec;
    angles[0] = 12'h000;
    angles[1] = 12'h192;
    angles[2] = 12'h324;
    angles[3] = 12'h5A0;
    for (int n = 0; n < 4; n++) begin
      applyStimulus(angles[n], lat, s, c);
      refTrig(angles[n], es, ec);
      checks++; if (lat !== 12) begin errors++; $display("[TB] FAIL corner_latency theta=%h got %0d want 12", angles[n], lat); end
      checks++; if (s - es > 3 || es - s > 3) begin errors++; $display("[TB] FAIL corner_sin theta=%h got %0d want %0d+/-3", angles[n], s, es); end
      checks++; if (c - ec > 3 || ec - c > 3) begin errors++; $display("[TB] FAIL corner_cos theta=%h got %0d want %0d+/-3", angles[n], c, ec); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL corner_idle theta=%h got %b want 0", angles[n], busy); end
    end
  endtask

  task automatic test_ignore_start;
    int doneCount, doneEdge, s, c, es, ec;
    doneCount = 0;
    doneEdge  = -1;
    s = 0;
    c = 0;
    start = 1'b1;
    theta = 12'h5A0;
    @(posedge Clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 3 || k == 12) begin
        start = 1'b1;
        theta = 12'h100;
      end
      @(posedge Clk); #1;
      start = 1'b0;
      if (k == 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ign_busy_iter got %b want 1", busy); end
      end
      if (k == 13) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ign_busy_end got %b want 0", busy); end
      end
      if (done === 1'b1) begin
        doneCount++;
        doneEdge = k;
        s = $signed(sin_out);
        c = $signed(cos_out);
      end
    end
    refTrig(12'h5A0, es, ec);
    checks++; if (doneCount !== 1) begin errors++; $display("[TB] FAIL ign_done_count got %0d want 1", doneCount); end
    checks++; if (doneEdge !== 12) begin errors++; $display("[TB] FAIL ign_done_edge got %0d want 12", doneEdge); end
    checks++; if (s - es > 3 || es - s > 3) begin errors++; $display("[TB] FAIL ign_sin got %0d want %0d+/-3", s, es); end
    checks++; if (c - ec > 3 || ec - c > 3) begin errors++; $display("[TB] FAIL ign_cos got %0d want %0d+/-3", c, ec); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ign_no_queue got %b want 0", busy); end
  endtask

  task automatic test_random;
    logic [11:0] th;
    int lat, s, c, es, ec;
    for (int n = 0; n < 16; n++) begin
      th = 12'($urandom_range(0, 12'h661));
      applyStimulus(th, lat, s, c);
      refTrig(th, es, ec);
      checks++; if (lat !== 12) begin errors++; $display("[TB] FAIL rand_latency theta=%h got %0d want 12", th, lat); end
      checks++; if (s - es > 3 || es - s > 3) begin errors++; $display("[TB] FAIL rand_sin theta=%h got %0d want %0d+/-3", th, s, es); end
      checks++; if (c - ec > 3 || ec - c > 3) begin errors++; $display("[TB] FAIL rand_cos theta=%h got %0d want %0d+/-3", th, c, ec); end
    end
  endtask

  task automatic test_reset_mid_iter;
    logic [11:0] th2;
    int earlyDone, doneEdge, s, c, es, ec;
    earlyDone = 0;
    doneEdge  = -1;
    s = 0;
    c = 0;
    th2 = 12'($urandom_range(0, 12'h661));
    start = 1'b1;
    theta = 12'h2A0;
    @(posedge Clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 6) Reset = 1'b1;
      if (k == 8) begin
        start = 1'b1;
        theta = th2;
      end
      @(posedge Clk); #1;
      Reset = 1'b0;
      start = 1'b0;
      if (k == 6) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy got %b want 0", busy); end
        checks++; if (sin_out !== 12'h000) begin errors++; $display("[TB] FAIL mid_sin got %h want 000", sin_out); end
        checks++; if (cos_out !== 12'h000) begin errors++; $display("[TB] FAIL mid_cos got %h want 000", cos_out); end
      end
      if (done === 1'b1) begin
        if (k < 8) earlyDone++;
        else if (doneEdge < 0) begin
          doneEdge = k;
          s = $signed(sin_out);
          c = $signed(cos_out);
        end
      end
    end
    refTrig(th2, es, ec);
    checks++; if (earlyDone !== 0) begin errors++; $display("[TB] FAIL mid_no_done got %0d want 0", earlyDone); end
    checks++; if (doneEdge !== 20) begin errors++; $display("[TB] FAIL mid_restart_edge got %0d want 20", doneEdge); end
    checks++; if (s - es > 3 || es - s > 3) begin errors++; $display("[TB] FAIL mid_sin_result got %0d want %0d+/-3", s, es); end
    checks++; if (c - ec > 3 || ec - c > 3) begin errors++; $display("[TB] FAIL mid_cos_result got %0d want %0d+/-3", c, ec); end
  endtask

  task automatic test_back_to_back;
    logic [11:0] q[$];
    logic [11:0] th;
    logic        expDone;
    int          s, c, es, ec, idx;
    th = 12'($urandom_range(0, 12'h661));
    q.push_back(th);
    start = 1'b1;
    theta = th;
    @(posedge Clk); #1;
    for (int k = 1; k <= 55; k++) begin
      th = 12'($urandom_range(0, 12'h661));
      theta = th;
      if (k % 14 == 0) q.push_back(th);
      @(posedge Clk); #1;
      expDone = (k >= 12) && ((k - 12) % 14 == 0);
      checks++; if (done !== expDone) begin errors++; $display("[TB] FAIL b2b_done edge=%0d got %b want %b", k, done, expDone); end
      if (expDone && done === 1'b1) begin
        idx = (k - 12) / 14;
        s = $signed(sin_out);
        c = $signed(cos_out);
        refTrig(q[idx], es, ec);
        checks++; if (s - es > 3 || es - s > 3) begin errors++; $display("[TB] FAIL b2b_sin theta=%h got %0d want %0d+/-3", q[idx], s, es); end
        checks++; if (c - ec > 3 || ec - c > 3) begin errors++; $display("[TB] FAIL b2b_cos theta=%h got %0d want %0d+/-3", q[idx], c, ec); end
      end
    end
    start = 1'b0;
    repeat (16) @(posedge Clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_corners();
    test_ignore_start();
    test_random();
    test_reset_mid_iter();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
